// File: rtl/mtx_hop_seq.sv
// mtx_hop_seq: frequency-hop sequencer feeding mtx_sig_tag_chip.
// A 16-bit Fibonacci LFSR picks each next channel. The new channel is
// presented one edge before the tag chip reloads its phase increment.
module mtx_hop_seq #(
  parameter int                     PHASE_WIDTH = 24,
  parameter int                     NSIG        = 32768,
  parameter int                     NSYMB       = 9,
  parameter int                     CNT_WIDTH   = 20,
  parameter int                     CH_BITS     = 4,
  parameter logic [PHASE_WIDTH-1:0] BASE_PH_INC = 24'h100000,
  parameter logic [PHASE_WIDTH-1:0] CH_SPACING  = 24'h010000,
  parameter logic [15:0]            LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   run,
  input  logic                   seed_load,
  input  logic [15:0]            seed,
  output logic                   srst,
  output logic [PHASE_WIDTH-1:0] hop_phase_inc,
  output logic                   phase_tvalid,
  output logic                   phase_tlast,
  input  logic                   phase_tready,
  output logic [CH_BITS-1:0]     hop_idx,
  output logic [15:0]            hop_count,
  output logic                   underrun
);

  localparam int DWELL = NSIG * NSYMB;
  localparam logic [CNT_WIDTH-1:0] DWELL_C    = CNT_WIDTH'(DWELL);
  localparam logic [CNT_WIDTH-1:0] DWELL_M1_C = CNT_WIDTH'(DWELL - 1);

  // PREP needs up to 4 cycles and must finish well before the next reload;
  // the dwell counter must also be able to hold the full dwell length.
  generate
    if ((DWELL < 8) || (DWELL > (2 ** CNT_WIDTH) - 1)) begin : g_bad_dwell
      $error("mtx_hop_seq: DWELL must be >= 8 and fit in CNT_WIDTH bits");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CH_BITS-1:0]   cur_idx_q, cur_idx_d;
  logic [CH_BITS-1:0]   next_idx_q, next_idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]          hop_count_q, hop_count_d;
  logic                 underrun_q, underrun_d;
  logic                 prep_busy_q, prep_busy_d;
  logic [1:0]           prep_rej_q, prep_rej_d;
  logic                 prep_start;
  logic [15:0]          lfsr_stepped;
  logic [CH_BITS-1:0]   cand;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      cur_idx_q   <= '0;
      next_idx_q  <= '0;
      cnt_q       <= '0;
      hop_count_q <= '0;
      underrun_q  <= 1'b0;
      prep_busy_q <= 1'b0;
      prep_rej_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cur_idx_q   <= cur_idx_d;
      next_idx_q  <= next_idx_d;
      cnt_q       <= cnt_d;
      hop_count_q <= hop_count_d;
      underrun_q  <= underrun_d;
      prep_busy_q <= prep_busy_d;
      prep_rej_q  <= prep_rej_d;
    end
  end

  // Next-state logic: main FSM, dwell counter and PREP channel search
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cur_idx_d    = cur_idx_q;
    next_idx_d   = next_idx_q;
    cnt_d        = cnt_q;
    hop_count_d  = hop_count_q;
    underrun_d   = underrun_q;
    prep_busy_d  = prep_busy_q;
    prep_rej_d   = prep_rej_q;
    prep_start   = 1'b0;
    lfsr_stepped = lfsr_step(lfsr_q);
    cand         = lfsr_stepped[CH_BITS-1:0];

    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          // An all-zero seed would lock the LFSR, so substitute 1
          lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (run) begin
          state_d   = S_SYNC;
          cur_idx_d = lfsr_q[CH_BITS-1:0];
          lfsr_d    = lfsr_stepped;
        end
      end
      S_SYNC: begin
        cnt_d      = CNT_WIDTH'(1);
        state_d    = S_RUN;
        prep_start = 1'b1;
      end
      S_RUN: begin
        // The tag chip consumes every clock, so a stall is only flagged
        if (!phase_tready) underrun_d = 1'b1;
        // Switch channel one edge ahead of the tag chip's reload edge
        if (cnt_q == DWELL_M1_C) cur_idx_d = next_idx_q;
        if (cnt_q == DWELL_C) begin
          hop_count_d = hop_count_q + 16'd1;
          if (run) begin
            cnt_d      = CNT_WIDTH'(1);
            prep_start = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // PREP only runs in the first cycles of a dwell, never in IDLE, so it
    // never competes with the IDLE-side LFSR updates above.
    if (prep_busy_q) begin
      lfsr_d = lfsr_stepped;
      if (cand != cur_idx_q) begin
        next_idx_d  = cand;
        prep_busy_d = 1'b0;
      end else if (prep_rej_q == 2'd3) begin
        next_idx_d  = cur_idx_q + CH_BITS'(1);
        prep_busy_d = 1'b0;
      end else begin
        prep_rej_d = prep_rej_q + 2'd1;
      end
    end
    if (prep_start) begin
      prep_busy_d = 1'b1;
      prep_rej_d  = '0;
    end
  end

  assign srst          = (state_q == S_SYNC);
  assign phase_tvalid  = (state_q == S_RUN);
  assign phase_tlast   = (state_q == S_RUN) && (cnt_q == DWELL_C);
  assign hop_idx       = cur_idx_q;
  assign hop_phase_inc = BASE_PH_INC + PHASE_WIDTH'(cur_idx_q) * CH_SPACING;
  assign hop_count     = hop_count_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_mtx_hop_seq.sv
// tb_mtx_hop_seq: directed bench for mtx_hop_seq with a behavioural model
// and a queue of expected channels checked at each SYNC and dwell end.
module tb_mtx_hop_seq;

  localparam logic [23:0] BASE = 24'h100000;
  localparam logic [23:0] SPC  = 24'h010000;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        run = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        phase_tready = 1'b1;
  logic        srst, phase_tvalid, phase_tlast, underrun;
  logic [23:0] hop_phase_inc;
  logic [1:0]  hop_idx;
  logic [15:0] hop_count;

  mtx_hop_seq #(
    .PHASE_WIDTH(24), .NSIG(4), .NSYMB(2), .CNT_WIDTH(20), .CH_BITS(2),
    .BASE_PH_INC(BASE), .CH_SPACING(SPC), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .aresetn(aresetn), .run(run), .seed_load(seed_load),
    .seed(seed), .srst(srst), .hop_phase_inc(hop_phase_inc),
    .phase_tvalid(phase_tvalid), .phase_tlast(phase_tlast),
    .phase_tready(phase_tready), .hop_idx(hop_idx), .hop_count(hop_count),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model (0=IDLE, 1=SYNC, 2=RUN)
  int          m_state;
  int          m_cnt;
  logic [15:0] m_lfsr;
  logic [1:0]  m_cur, m_next, last_hop;
  logic [15:0] m_hops;
  logic        m_under;
  logic [23:0] prev_inc;
  logic [1:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic m_reset();
    m_state = 0; m_cnt = 0; m_lfsr = 16'hACE1; m_cur = 2'd0; m_next = 2'd0;
    m_hops = 16'd0; m_under = 1'b0; last_hop = 2'd0; prev_inc = BASE;
    exp_q.delete();
  endtask

  // Up to 4 candidates; fall back to the neighbouring channel
  task automatic m_prep();
    logic done;
    done   = 1'b0;
    m_next = m_cur + 2'd1;
    for (int k = 0; k < 4; k++) begin
      if (!done) begin
        m_lfsr = f_step(m_lfsr);
        if (m_lfsr[1:0] != m_cur) begin
          m_next = m_lfsr[1:0];
          done   = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge();
    if (!aresetn) begin
      m_reset();
    end else begin
      if (m_state == 2 && !phase_tready) m_under = 1'b1;
      case (m_state)
        0: begin
          if (seed_load) m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
          else if (run) begin
            m_cur = m_lfsr[1:0];
            m_lfsr = f_step(m_lfsr);
            exp_q.push_back(m_cur);
            m_state = 1;
          end
        end
        1: begin m_cnt = 1; m_state = 2; m_prep(); end
        default: begin
          if (m_cnt == 7) begin m_cur = m_next; exp_q.push_back(m_cur); end
          if (m_cnt == 8) begin
            m_hops = m_hops + 16'd1;
            if (run) begin m_cnt = 1; m_prep(); end
            else begin m_cnt = 0; m_state = 0; end
          end else m_cnt++;
        end
      endcase
    end
  endtask

  task automatic check_cycle();
    logic [1:0]  pop;
    logic [23:0] e_inc;
    e_inc = BASE + {22'd0, m_cur} * SPC;
    chk("srst", 32'(srst), 32'(m_state == 1));
    chk("tvalid", 32'(phase_tvalid), 32'(m_state == 2));
    chk("tlast", 32'(phase_tlast), 32'(m_state == 2 && m_cnt == 8));
    chk("hop_idx", 32'(hop_idx), 32'(m_cur));
    chk("phase_inc", 32'(hop_phase_inc), 32'(e_inc));
    chk("hop_count", 32'(hop_count), 32'(m_hops));
    chk("underrun", 32'(underrun), 32'(m_under));
    if (m_state == 2 && hop_phase_inc !== prev_inc)
      chk("inc_before_tlast", 32'(phase_tlast), 32'd1);
    prev_inc = hop_phase_inc;
    if (m_state == 1 || (m_state == 2 && m_cnt == 8)) begin
      if (exp_q.size() == 0) begin
        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        pop = exp_q.pop_front();
        chk("sb_hop", 32'(hop_idx), 32'(pop));
        if (m_state == 2) chk("hop_differs", 32'(hop_idx != last_hop), 32'd1);
        last_hop = pop;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_srst"}, 32'(srst), 32'd0);
    chk({tag, "_tvalid"}, 32'(phase_tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(phase_tlast), 32'd0);
    chk({tag, "_idx"}, 32'(hop_idx), 32'd0);
    chk({tag, "_inc"}, 32'(hop_phase_inc), 32'(BASE));
    chk({tag, "_count"}, 32'(hop_count), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  task automatic do_reset();
    run = 1'b0; seed_load = 1'b0; phase_tready = 1'b1;
    aresetn = 1'b0;
    m_reset();
    repeat (2) tick();
    aresetn = 1'b1;
  endtask

  // Seed whose first pick c is followed by 4 candidates equal to c
  function automatic logic [15:0] find_rej_seed();
    logic [15:0] l;
    logic [1:0]  c;
    logic        ok;
    for (int s = 1; s < 65536; s++) begin
      l = 16'(s); c = l[1:0]; l = f_step(l); ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        l = f_step(l);
        if (l[1:0] != c) ok = 1'b0;
      end
      if (ok) return 16'(s);
    end
    return 16'h0000;
  endfunction

  initial begin
    int          n_tl;
    logic [15:0] rs;

    // Reset state
    do_reset();
    chk_reset_vals("rst");

    // Start: one-cycle SYNC with channel 1 from seed 0xACE1
    run = 1'b1;
    tick();
    chk("start_srst", 32'(srst), 32'd1);
    chk("start_idx", 32'(hop_idx), 32'd1);
    chk("start_inc", 32'(hop_phase_inc), 32'h110000);
    tick();
    chk("start_srst_low", 32'(srst), 32'd0);
    chk("start_tvalid", 32'(phase_tvalid), 32'd1);

    // Free run for 10 hops
    n_tl = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (phase_tlast) n_tl++;
    end
    chk("tlast_count", 32'(n_tl), 32'd10);
    chk("hop_count_10", 32'(hop_count), 32'd10);

    // One stalled RUN cycle sets the sticky underrun flag
    phase_tready = 1'b0;
    tick();
    phase_tready = 1'b1;
    tick();
    chk("underrun_set", 32'(underrun), 32'd1);

    // Drop run at cnt=3: the dwell still completes
    for (int i = 0; i < 16 && m_cnt != 3; i++) tick();
    chk("at_cnt3", 32'(m_cnt), 32'd3);
    run = 1'b0;
    for (int i = 0; i < 16 && m_cnt != 8; i++) tick();
    chk("stop_tlast", 32'(phase_tlast), 32'd1);
    tick();
    chk("stop_tvalid", 32'(phase_tvalid), 32'd0);
    repeat (3) tick();
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Async reset mid-RUN takes effect with no clock edge
    run = 1'b1;
    repeat (12) tick();
    aresetn = 1'b0;
    #2;
    chk_reset_vals("async");
    m_reset();
    tick();
    aresetn = 1'b1;
    run = 1'b0;
    tick();

    // Seed 0 maps to 1; seed_load has priority over run
    seed = 16'h0000; seed_load = 1'b1; run = 1'b1;
    tick();
    chk("seedld_priority", 32'(srst), 32'd0);
    seed_load = 1'b0;
    tick();
    chk("seed0_idx", 32'(hop_idx), 32'd1);
    repeat (20) tick();

    // Four rejections force next = cur+1
    do_reset();
    rs = find_rej_seed();
    if (rs == 16'h0000) begin
      n_err++;
      $display("FAIL rej4_seed: no seed found");
    end
    seed = rs; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; run = 1'b1;
    tick();
    chk("rej4_first", 32'(hop_idx), 32'(rs[1:0]));
    for (int i = 0; i < 16 && m_cnt != 8; i++) tick();
    chk("rej4_next", 32'(hop_idx), 32'(2'(rs[1:0] + 2'd1)));
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
